// File: rtl/dma_fifo_pkg.sv
`default_nettype none
// ============================================================================
// dma_fifo_pkg : shared types and constants for the DMA longword staging FIFO
// Revision     : 1.0
// ============================================================================
package dma_fifo_pkg;

    // Byte-pointer / byte-lane index: lane 0 = bits 7:0 ... lane 3 = bits 31:24
    typedef logic [1:0] bptr_t;

    localparam bptr_t c_lane0 = 2'd0;
    localparam bptr_t c_lane1 = 2'd1;
    localparam bptr_t c_lane2 = 2'd2;
    localparam bptr_t c_lane3 = 2'd3;

    localparam int c_depth = 8;
    localparam int c_ptr_w = 3;

endpackage
`default_nettype wire

// File: rtl/dma_fifo_if.sv
`default_nettype none
// ============================================================================
// dma_fifo_if : datapath <-> staging FIFO handshake and status bundle
// Revision    : 1.0
// ============================================================================
interface dma_fifo_if;

    logic [31:0] FIFO_ID;
    logic        LLWORD;
    logic        LHWORD;
    logic        LBYTE;
    logic        INCFIFO;
    logic        DECFIFO;
    logic        INCBPTR;
    logic        ACR;
    logic [31:0] FIFO_OD;
    logic        BO0;
    logic        BO1;
    logic        BOEQ3;
    logic        FIFOFULL;
    logic        FIFOEMPTY;

    modport master (
        output FIFO_ID, LLWORD, LHWORD, LBYTE, INCFIFO, DECFIFO, INCBPTR, ACR,
        input  FIFO_OD, BO0, BO1, BOEQ3, FIFOFULL, FIFOEMPTY
    );

    modport slave (
        input  FIFO_ID, LLWORD, LHWORD, LBYTE, INCFIFO, DECFIFO, INCBPTR, ACR,
        output FIFO_OD, BO0, BO1, BOEQ3, FIFOFULL, FIFOEMPTY
    );

endinterface
`default_nettype wire

// File: rtl/dma_fifo_byte_ptr.sv
`default_nettype none
// ============================================================================
// fifo_byte_ptr : 2-bit byte-lane pointer with flush, decodes BO0/BO1/BOEQ3
// Revision      : 1.0
// ============================================================================
module fifo_byte_ptr
    import dma_fifo_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst_n,
    input  wire logic  i_clr,
    input  wire logic  i_inc,
    output bptr_t      o_bptr,
    output logic       o_bo0,
    output logic       o_bo1,
    output logic       o_boeq3
);

    bptr_t r_bptr;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_bptr <= c_lane0;
        end else if (i_inc) begin
            r_bptr <= r_bptr + 2'd1;
        end
    end

    assign o_bptr  = r_bptr;
    assign o_bo0   = r_bptr[0];
    assign o_bo1   = r_bptr[1];
    assign o_boeq3 = (r_bptr == c_lane3);

endmodule
`default_nettype wire

// File: rtl/dma_fifo.sv
`default_nettype none
// ============================================================================
// dma_fifo : longword staging FIFO with byte/word lane writes and byte pointer
// Revision : 1.0
// ============================================================================
module dma_fifo
    import dma_fifo_pkg::*;
#(
    parameter int DEPTH = c_depth,
    parameter int PTR_W = c_ptr_w
) (
    input  wire logic  CLK,
    input  wire logic  RESET_,
    dma_fifo_if.slave  bus
);

    localparam logic [PTR_W-1:0] c_ptr_one = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   c_cnt_one = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   c_cnt_full = (PTR_W+1)'(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    bptr_t            w_bptr;
    logic [3:0]       w_lane_we;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    fifo_byte_ptr u_byte_ptr (
        .clk     (CLK),
        .rst_n   (RESET_),
        .i_clr   (bus.ACR),
        .i_inc   (bus.INCBPTR),
        .o_bptr  (w_bptr),
        .o_bo0   (bus.BO0),
        .o_bo1   (bus.BO1),
        .o_boeq3 (bus.BOEQ3)
    );

    assign w_full  = (r_count == c_cnt_full);
    assign w_empty = (r_count == '0);
    // Push/pop are gated on the pre-edge count, so full+both pops only and empty+both pushes only
    assign w_push  = bus.INCFIFO && !w_full;
    assign w_pop   = bus.DECFIFO && !w_empty;

    always_comb begin
        w_lane_we          = 4'b0000;
        w_lane_we[c_lane0] = bus.LLWORD;
        w_lane_we[c_lane1] = bus.LLWORD;
        w_lane_we[c_lane2] = bus.LHWORD;
        w_lane_we[c_lane3] = bus.LHWORD;
        if (bus.LBYTE) begin
            w_lane_we[w_bptr] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.ACR) begin
            // Flush keeps memory contents; only the bookkeeping is cleared
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            for (int l = 0; l < 4; l++) begin
                if (w_lane_we[l]) begin
                    r_mem[r_wptr][l*8 +: 8] <= bus.FIFO_ID[l*8 +: 8];
                end
            end
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.FIFO_OD   = r_mem[r_rptr];
    assign bus.FIFOFULL  = w_full;
    assign bus.FIFOEMPTY = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_dma_fifo.sv
`default_nettype none
// ============================================================================
// tb_dma_fifo : directed + randomized self-checking bench for dma_fifo
// Revision    : 1.0
// ============================================================================
module tb_dma_fifo;

    localparam int c_depth = 8;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    dma_fifo_if bus ();

    dma_fifo #(.DEPTH(c_depth), .PTR_W(3)) dut (
        .CLK    (clk),
        .RESET_ (reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: array of longwords, modular pointers and an occupancy count
    logic [31:0] m_mem [c_depth];
    int          m_wptr;
    int          m_rptr;
    int          m_count;
    int          m_bptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit push;
        bit pop;
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) m_mem[i] = '0;
            m_wptr = 0; m_rptr = 0; m_count = 0; m_bptr = 0;
        end else if (bus.ACR) begin
            m_wptr = 0; m_rptr = 0; m_count = 0; m_bptr = 0;
        end else begin
            if (bus.LLWORD) m_mem[m_wptr][15:0]  = bus.FIFO_ID[15:0];
            if (bus.LHWORD) m_mem[m_wptr][31:16] = bus.FIFO_ID[31:16];
            if (bus.LBYTE)  m_mem[m_wptr][m_bptr*8 +: 8] = bus.FIFO_ID[m_bptr*8 +: 8];
            push = bus.INCFIFO && (m_count < c_depth);
            pop  = bus.DECFIFO && (m_count > 0);
            if (push) begin m_wptr = (m_wptr + 1) % c_depth; m_count++; end
            if (pop)  begin m_rptr = (m_rptr + 1) % c_depth; m_count--; end
            if (bus.INCBPTR) m_bptr = (m_bptr + 1) % 4;
        end
    endtask

    task automatic check_all();
        check_eq("FIFO_OD",   bus.FIFO_OD,   m_mem[m_rptr]);
        check_eq("BPTR",      {30'd0, bus.BO1, bus.BO0}, 32'(m_bptr));
        check_eq("BOEQ3",     {31'd0, bus.BOEQ3},     {31'd0, m_bptr == 3});
        check_eq("FIFOFULL",  {31'd0, bus.FIFOFULL},  {31'd0, m_count == c_depth});
        check_eq("FIFOEMPTY", {31'd0, bus.FIFOEMPTY}, {31'd0, m_count == 0});
    endtask

    task automatic idle();
        bus.FIFO_ID = '0; bus.LLWORD = 0; bus.LHWORD = 0; bus.LBYTE = 0;
        bus.INCFIFO = 0;  bus.DECFIFO = 0; bus.INCBPTR = 0; bus.ACR = 0;
        reset_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        idle();
    endtask

    task automatic push_lw(input logic [31:0] d);
        bus.FIFO_ID = d; bus.LLWORD = 1; bus.LHWORD = 1; bus.INCFIFO = 1;
        tick();
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] d);
        check_eq(tag, bus.FIFO_OD, d);
        bus.DECFIFO = 1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < c_depth; i++) m_mem[i] = '0;
        m_wptr = 0; m_rptr = 0; m_count = 0; m_bptr = 0;
        idle();

        // 1: reset then idle
        reset_n = 1'b0;
        @(posedge clk); model_step(); #1;
        reset_n = 1'b0;
        tick();
        tick();
        check_eq("rst_od",    bus.FIFO_OD, 32'h0);
        check_eq("rst_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);
        check_eq("rst_full",  {31'd0, bus.FIFOFULL},  32'd0);
        check_eq("rst_bo",    {30'd0, bus.BO1, bus.BO0}, 32'd0);

        // 2: longword path
        push_lw(32'hDEADBEEF);
        check_eq("lw_empty", {31'd0, bus.FIFOEMPTY}, 32'd0);
        check_eq("lw_od",    bus.FIFO_OD, 32'hDEADBEEF);
        bus.DECFIFO = 1;
        tick();
        check_eq("lw_pop_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);

        // 3: byte path, lane k carries the k-th byte, other lanes hold junk
        for (int k = 0; k < 4; k++) begin
            logic [31:0] id;
            logic [7:0]  b;
            id = $urandom;
            b  = 8'(8'h11 * (k + 1));
            id[k*8 +: 8] = b;
            if (k == 3) check_eq("byte_boeq3_pre", {31'd0, bus.BOEQ3}, 32'd1);
            bus.FIFO_ID = id; bus.LBYTE = 1; bus.INCBPTR = 1;
            if (k == 3) bus.INCFIFO = 1;
            tick();
        end
        check_eq("byte_bptr0", {30'd0, bus.BO1, bus.BO0}, 32'd0);
        check_eq("byte_od",    bus.FIFO_OD, 32'h44332211);
        bus.DECFIFO = 1;
        tick();

        // 4: fill from pointer 0, ignored overfill, drain in order
        bus.ACR = 1;
        tick();
        for (int i = 0; i < c_depth; i++) push_lw(32'(i));
        check_eq("fill_full", {31'd0, bus.FIFOFULL}, 32'd1);
        bus.FIFO_ID = 32'hBAD0BAD0; bus.INCFIFO = 1;
        tick();
        check_eq("overfill_full", {31'd0, bus.FIFOFULL}, 32'd1);
        for (int i = 0; i < c_depth; i++) pop_expect("drain_order", 32'(i));
        check_eq("drain_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);

        // 5: simultaneous push/pop at count 3, full, and empty
        for (int i = 0; i < 3; i++) push_lw(32'hA0 + 32'(i));
        bus.FIFO_ID = 32'hA3; bus.LLWORD = 1; bus.LHWORD = 1;
        bus.INCFIFO = 1; bus.DECFIFO = 1;
        tick();
        for (int i = 1; i < 4; i++) pop_expect("both_mid_order", 32'hA0 + 32'(i));
        check_eq("both_mid_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);
        for (int i = 0; i < c_depth; i++) push_lw(32'hB0 + 32'(i));
        bus.INCFIFO = 1; bus.DECFIFO = 1;
        tick();
        check_eq("both_full_notfull", {31'd0, bus.FIFOFULL}, 32'd0);
        for (int i = 1; i < c_depth; i++) pop_expect("both_full_order", 32'hB0 + 32'(i));
        check_eq("both_full_count7", {31'd0, bus.FIFOEMPTY}, 32'd1);
        bus.FIFO_ID = 32'hC0FFEE00; bus.LLWORD = 1; bus.LHWORD = 1;
        bus.INCFIFO = 1; bus.DECFIFO = 1;
        tick();
        check_eq("both_empty_od", bus.FIFO_OD, 32'hC0FFEE00);
        pop_expect("both_empty_pop", 32'hC0FFEE00);
        check_eq("both_empty_count1", {31'd0, bus.FIFOEMPTY}, 32'd1);

        // 6: flush with count 5 and bptr 2, then reset during a push
        for (int i = 0; i < 5; i++) push_lw(32'hD0 + 32'(i));
        bus.INCBPTR = 1; tick();
        bus.INCBPTR = 1; tick();
        bus.ACR = 1; bus.INCFIFO = 1; bus.LLWORD = 1; bus.FIFO_ID = 32'hFFFF;
        tick();
        check_eq("acr_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);
        check_eq("acr_bptr",  {30'd0, bus.BO1, bus.BO0}, 32'd0);
        check_eq("acr_od_retained", bus.FIFO_OD, m_mem[0]);
        bus.FIFO_ID = 32'h12345678; bus.LLWORD = 1; bus.LHWORD = 1; bus.INCFIFO = 1;
        reset_n = 1'b0;
        tick();
        check_eq("rst_mid_empty", {31'd0, bus.FIFOEMPTY}, 32'd1);
        check_eq("rst_mid_od",    bus.FIFO_OD, 32'h0);
        for (int i = 0; i < 3; i++) begin bus.INCFIFO = 1; tick(); end
        for (int i = 0; i < 3; i++) pop_expect("rst_mem_zero", 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bus.FIFO_ID = $urandom;
            bus.LLWORD  = ($urandom_range(0, 3) == 0);
            bus.LHWORD  = ($urandom_range(0, 3) == 0);
            bus.LBYTE   = ($urandom_range(0, 2) == 0);
            bus.INCFIFO = ($urandom_range(0, 1) == 0);
            bus.DECFIFO = ($urandom_range(0, 2) == 0);
            bus.INCBPTR = ($urandom_range(0, 1) == 0);
            bus.ACR     = ($urandom_range(0, 63) == 0);
            reset_n     = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
